// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: opcodes, operand mux selects,
// FSM state and shift-kind types, plus small opcode classification helpers.
package alu_pkg;

    localparam logic [3:0] ALU_SLL     = 4'b0000;
    localparam logic [3:0] ALU_SRL     = 4'b0001;
    localparam logic [3:0] ALU_SRA     = 4'b0010;
    localparam logic [3:0] ALU_SLLV    = 4'b0011;
    localparam logic [3:0] ALU_SRLV    = 4'b0100;
    localparam logic [3:0] ALU_SRAV    = 4'b0101;
    localparam logic [3:0] ALU_ADD     = 4'b0110;
    localparam logic [3:0] ALU_SUB     = 4'b0111;
    localparam logic [3:0] ALU_AND     = 4'b1000;
    localparam logic [3:0] ALU_OR      = 4'b1001;
    localparam logic [3:0] ALU_XOR     = 4'b1010;
    localparam logic [3:0] ALU_NOR     = 4'b1011;
    localparam logic [3:0] ALU_SLT     = 4'b1100;
    localparam logic [3:0] ALU_SLTU    = 4'b1101;
    localparam logic [3:0] ALU_LUI     = 4'b1110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    localparam logic [1:0] IN1_RT   = 2'b00;
    localparam logic [1:0] IN1_SIMM = 2'b01;
    localparam logic [1:0] IN1_ZIMM = 2'b10;
    localparam logic [1:0] IN1_ZERO = 2'b11;

    localparam logic IN2_RS    = 1'b0;
    localparam logic IN2_SHAMT = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_t;

    function automatic logic is_shift(input logic [3:0] op);
        return op <= ALU_SRAV;
    endfunction

    function automatic shift_t shift_kind(input logic [3:0] op);
        shift_t k;
        case (op)
            ALU_SLL, ALU_SLLV: k = SH_LL;
            ALU_SRL, ALU_SRLV: k = SH_RL;
            default:           k = SH_RA;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shifter datapath for alu_exec. Default build: one-bit step of the
// working value per call. ALU_EXEC_FAST_SHIFT_EN: full barrel shift by amt.
// Ports: data in, amt in (fast build only), kind in, result out.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
`ifdef ALU_EXEC_FAST_SHIFT_EN
    input  logic [4:0]       amt,
`endif
    input  shift_t           kind,
    output logic [WIDTH-1:0] result
);

`ifdef ALU_EXEC_FAST_SHIFT_EN
    always_comb begin
        case (kind)
            SH_LL:   result = data << amt;
            SH_RL:   result = data >> amt;
            default: result = WIDTH'($signed(data) >>> amt);
        endcase
    end
`else
    always_comb begin
        case (kind)
            SH_LL:   result = {data[WIDTH-2:0], 1'b0};
            SH_RL:   result = {1'b0, data[WIDTH-1:1]};
            default: result = {data[WIDTH-1], data[WIDTH-1:1]};
        endcase
    end
`endif

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready request and response handshakes.
// Ports: clk, rst_n, in_valid/in_ready, in1_mux, in2_mux, alu_op, rt, rs,
// imm, shamt; out_valid/out_ready, result, zero, ovf, illegal.
// Macro ALU_EXEC_FAST_SHIFT_EN selects a single-cycle barrel shifter;
// otherwise shifts iterate one bit per cycle in the SHIFT state.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in1_mux,
    input  logic             in2_mux,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] rs,
    input  logic [15:0]      imm,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    state_t           state;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;
    logic             ill_c;
    logic [WIDTH-1:0] sh_res;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    always_comb begin
        case (in1_mux)
            IN1_RT:   a_in = rt;
            IN1_SIMM: a_in = {{(WIDTH-16){imm[15]}}, imm};
            IN1_ZIMM: a_in = {{(WIDTH-16){1'b0}}, imm};
            default:  a_in = '0;
        endcase
        b_in = (in2_mux == IN2_SHAMT) ? {{(WIDTH-5){1'b0}}, shamt} : rs;
    end

`ifdef ALU_EXEC_FAST_SHIFT_EN
    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .data   (a_in),
        .amt    (b_in[4:0]),
        .kind   (shift_kind(alu_op)),
        .result (sh_res)
    );
`else
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] step;
    logic [4:0]       cnt;
    shift_t           kind;

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .data   (work),
        .kind   (kind),
        .result (step)
    );

    // Only a zero-amount shift finishes at accept; it returns A unchanged.
    assign sh_res = a_in;
`endif

    assign sum  = b_in + a_in;
    assign diff = b_in - a_in;

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        ill_c = 1'b0;
        case (alu_op)
            ALU_SLL, ALU_SRL, ALU_SRA,
            ALU_SLLV, ALU_SRLV, ALU_SRAV: res_c = sh_res;
            ALU_ADD: begin
                res_c = sum;
                ovf_c = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                        (sum[WIDTH-1] != b_in[WIDTH-1]);
            end
            ALU_SUB: begin
                res_c = diff;
                ovf_c = (a_in[WIDTH-1] != b_in[WIDTH-1]) &&
                        (diff[WIDTH-1] != b_in[WIDTH-1]);
            end
            ALU_AND: res_c = b_in & a_in;
            ALU_OR:  res_c = b_in | a_in;
            ALU_XOR: res_c = b_in ^ a_in;
            ALU_NOR: res_c = ~(b_in | a_in);
            ALU_SLT:
                res_c = {{(WIDTH-1){1'b0}},
                         $signed(b_in) < $signed(a_in)};
            ALU_SLTU:
                res_c = {{(WIDTH-1){1'b0}}, b_in < a_in};
            ALU_LUI: res_c = {a_in[15:0], 16'b0};
            default: ill_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            cnt       <= '0;
            work      <= '0;
            kind      <= SH_LL;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready  <= 1'b0;
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= res_c;
                        zero      <= (res_c == '0);
                        ovf       <= ovf_c;
                        illegal   <= ill_c;
`ifndef ALU_EXEC_FAST_SHIFT_EN
                        if (is_shift(alu_op) && b_in[4:0] != 5'd0) begin
                            state     <= S_SHIFT;
                            out_valid <= 1'b0;
                            cnt       <= b_in[4:0];
                            work      <= a_in;
                            kind      <= shift_kind(alu_op);
                        end
`endif
                    end
                end
`ifndef ALU_EXEC_FAST_SHIFT_EN
                S_SHIFT: begin
                    work <= step;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= step;
                        zero      <= (step == '0);
                        ovf       <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: table of directed operations with
// expected outputs and latency, plus reset and backpressure sequences.
module tb_alu_exec;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in1_mux = 2'b00;
    logic        in2_mux = 1'b0;
    logic [3:0]  alu_op = 4'b0000;
    logic [31:0] rt = '0;
    logic [31:0] rs = '0;
    logic [15:0] imm = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1_mux   (in1_mux),
        .in2_mux   (in2_mux),
        .alu_op    (alu_op),
        .rt        (rt),
        .rs        (rs),
        .imm       (imm),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  m1;
        logic        m2;
        logic [3:0]  op;
        logic [31:0] rt;
        logic [31:0] rs;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        il;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int k);
`ifdef ALU_EXEC_FAST_SHIFT_EN
        return 1 + 0 * k;
`else
        return 1 + k;
`endif
    endfunction

    function automatic vec_t mk(
        input string n, input logic [1:0] m1, input logic m2,
        input logic [3:0] op, input logic [31:0] vrt, input logic [31:0] vrs,
        input logic [15:0] vimm, input logic [4:0] vsh,
        input logic [31:0] res, input logic z, input logic o,
        input logic il, input int k);
        vec_t v;
        v.name = n; v.m1 = m1; v.m2 = m2; v.op = op;
        v.rt = vrt; v.rs = vrs; v.imm = vimm; v.shamt = vsh;
        v.res = res; v.z = z; v.o = o; v.il = il; v.lat = lat_of(k);
        return v;
    endfunction

    task automatic wait_ready(input string name);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        in1_mux = v.m1; in2_mux = v.m2; alu_op = v.op;
        rt = v.rt; rs = v.rs; imm = v.imm; shamt = v.shamt;
        in_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        wait_ready(v.name);
        apply(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({v.name, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({v.name, "_lat"}, lat, v.lat);
        chk({v.name, "_result"}, result, v.res);
        chk({v.name, "_zero"}, {31'b0, zero}, {31'b0, v.z});
        chk({v.name, "_ovf"}, {31'b0, ovf}, {31'b0, v.o});
        chk({v.name, "_illegal"}, {31'b0, illegal}, {31'b0, v.il});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({v.name, "_drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int seen;

        vecs[0]  = mk("add_ovf", 2'b00, 1'b0, 4'h6, 32'h1, 32'h7FFFFFFF,
                      16'h0, 5'd0, 32'h80000000, 0, 1, 0, 0);
        vecs[1]  = mk("sub_zero", 2'b00, 1'b0, 4'h7, 32'h5, 32'h5,
                      16'h0, 5'd0, 32'h0, 1, 0, 0, 0);
        vecs[2]  = mk("slti", 2'b01, 1'b0, 4'hC, 32'h0, 32'hFFFFFFFF,
                      16'h0001, 5'd0, 32'h1, 0, 0, 0, 0);
        vecs[3]  = mk("sra4", 2'b00, 1'b1, 4'h2, 32'h80000000, 32'h0,
                      16'h0, 5'd4, 32'hF8000000, 0, 0, 0, 4);
        vecs[4]  = mk("lui", 2'b10, 1'b0, 4'hE, 32'h0, 32'h0,
                      16'h1234, 5'd0, 32'h12340000, 0, 0, 0, 0);
        vecs[5]  = mk("illegal", 2'b00, 1'b0, 4'hF, 32'h55, 32'hAA,
                      16'h0, 5'd0, 32'h0, 1, 0, 1, 0);
        vecs[6]  = mk("sll31", 2'b00, 1'b1, 4'h0, 32'h1, 32'h0,
                      16'h0, 5'd31, 32'h80000000, 0, 0, 0, 31);
        vecs[7]  = mk("srlv4", 2'b00, 1'b0, 4'h4, 32'hF0000000, 32'h24,
                      16'h0, 5'd0, 32'h0F000000, 0, 0, 0, 4);
        vecs[8]  = mk("sll0", 2'b00, 1'b1, 4'h0, 32'h0000ABCD, 32'h0,
                      16'h0, 5'd0, 32'h0000ABCD, 0, 0, 0, 0);
        vecs[9]  = mk("sltu", 2'b00, 1'b0, 4'hD, 32'hFFFFFFFF, 32'h1,
                      16'h0, 5'd0, 32'h1, 0, 0, 0, 0);
        vecs[10] = mk("slt_neg", 2'b00, 1'b0, 4'hC, 32'hFFFFFFFF, 32'h1,
                      16'h0, 5'd0, 32'h0, 1, 0, 0, 0);
        vecs[11] = mk("nor", 2'b00, 1'b0, 4'hB, 32'h0, 32'h0,
                      16'h0, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0);
        vecs[12] = mk("xor", 2'b00, 1'b0, 4'hA, 32'h0FF00FF0, 32'hFF00FF00,
                      16'h0, 5'd0, 32'hF0F0F0F0, 0, 0, 0, 0);
        vecs[13] = mk("sub_ovf", 2'b00, 1'b0, 4'h7, 32'h1, 32'h80000000,
                      16'h0, 5'd0, 32'h7FFFFFFF, 0, 1, 0, 0);
        vecs[14] = mk("addi_neg", 2'b01, 1'b0, 4'h6, 32'h0, 32'h10,
                      16'hFFFF, 5'd0, 32'h0000000F, 0, 0, 0, 0);
        vecs[15] = mk("srav31", 2'b00, 1'b0, 4'h5, 32'h80000000, 32'd31,
                      16'h0, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 31);
        vecs[16] = mk("and_zero", 2'b11, 1'b0, 4'h8, 32'hFFFF, 32'hFFFFFFFF,
                      16'h0, 5'd0, 32'h0, 1, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'b0, zero, ovf, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a long shift: srl by 20
        v = mk("srl20", 2'b00, 1'b1, 4'h1, 32'hFFFFFFFF, 32'h0,
               16'h0, 5'd20, 32'h00000FFF, 0, 0, 0, 20);
        wait_ready("mid_rst");
        apply(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        out_ready = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("mid_rst_no_stale", seen, 0);
        run_vec(v);

        // Backpressure on ori, with stray requests that must be ignored
        v = mk("ori", 2'b10, 1'b0, 4'h9, 32'h0, 32'hF0,
               16'h000F, 5'd0, 32'h000000FF, 0, 0, 0, 0);
        wait_ready("bp");
        apply(v);
        @(posedge clk);
        #1;
        chk("bp_valid0", {31'b0, out_valid}, 32'd1);
        alu_op = 4'h6;
        rs = 32'h12345678;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_result", result, 32'h000000FF);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("bp_not_queued", seen, 0);

        // Reset while holding a result in DONE
        v = mk("xor_hold", 2'b00, 1'b0, 4'hA, 32'h1, 32'h3,
               16'h0, 5'd0, 32'h2, 0, 0, 0, 0);
        wait_ready("done_rst");
        apply(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("done_rst_pre", result, 32'h2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("done_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("done_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
